load_align_extend: RTL and testbench

//  Load-data unit in the MEM stage. Takes a load request (byte offset, size, sign mode, dest tag) and fetches one or two memory words.

---
 rtl/load_pkg.sv | 36 +++
 rtl/lane_extract_extend.sv | 44 ++++
 rtl/load_align_extend.sv | 181 ++++++++++++++++++
 tb/tb_load_align_extend.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_pkg                                               |
// | Description : Shared load-size encodings, FSM state type and the     |
// |               byte-count helper for the load align/extend unit.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package load_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_FULL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FETCH_LO = 2'd1,
      ST_FETCH_HI = 2'd2,
      ST_RESP     = 2'd3
   } state_e;

   // Number of bytes a load of the given size returns; nb_full is the
   // byte count of a full data word.
   function automatic int nbytes(input logic [1:0] size, input int nb_full);
      int n;
      case (size)
         SZ_BYTE: n = 1;
         SZ_HALF: n = 2;
         SZ_WORD: n = 4;
         default: n = nb_full;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_extract_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lane_extract_extend                                    |
// | Description : Combinational byte-lane extractor. Shifts the {hi,lo}  |
// |               word pair down by the byte offset, keeps the addressed |
// |               bytes and sign- or zero-extends them to DATA_W.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lane_extract_extend
   import load_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]         i_hi,
   input  logic [DATA_W-1:0]         i_lo,
   input  logic [$clog2(DATA_W/8)-1:0] i_offset,
   input  logic [1:0]                i_size,
   input  logic                      i_sign,
   output logic [DATA_W-1:0]         o_data
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(2 * DATA_W);

   logic [2*DATA_W-1:0] w_window;
   int                  w_nbits;
   logic [IDX_W-1:0]    w_top_idx;
   logic                w_fill;

   // Shift the byte window into place, then replace everything above the
   // kept bytes with the extension bit.
   always_comb begin
      w_window  = {i_hi, i_lo} >> {i_offset, 3'b000};
      w_nbits   = 8 * nbytes(i_size, NB);
      w_top_idx = IDX_W'(w_nbits - 1);
      w_fill    = i_sign & w_window[w_top_idx];
      o_data    = '0;
      for (int i = 0; i < DATA_W; i++) begin
         o_data[i] = (i < w_nbits) ? w_window[i] : w_fill;
      end
   end

endmodule
`default_nettype wire

// File: rtl/load_align_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_align_extend                                      |
// | Description : MEM-stage load unit. Accepts a load request, fetches   |
// |               one or two memory words, aligns and extends the data   |
// |               and presents it to write-back with valid/ready.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_align_extend
   import load_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TAG_W          = 5,
   parameter int ALLOW_MISALIGN = 1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [$clog2(DATA_W/8)-1:0] req_offset,
   input  logic [1:0]                  req_size,
   input  logic                        req_sign,
   input  logic [TAG_W-1:0]            req_tag,
   output logic                        mem_req_valid,
   output logic                        mem_req_hi,
   input  logic                        mem_rsp_valid,
   input  logic [DATA_W-1:0]           mem_rsp_data,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [DATA_W-1:0]           resp_data,
   output logic [TAG_W-1:0]            resp_tag,
   output logic                        resp_err
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   state_e              state_q,     state_d;
   logic [OFF_W-1:0]    offset_q,    offset_d;
   logic [1:0]          size_q,      size_d;
   logic                sign_q,      sign_d;
   logic                split_q,     split_d;
   logic [TAG_W-1:0]    tag_q,       tag_d;
   logic [DATA_W-1:0]   lo_q,        lo_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic [TAG_W-1:0]    resp_tag_q,  resp_tag_d;
   logic                resp_err_q,  resp_err_d;

   logic                w_req_split;
   logic [DATA_W-1:0]   w_ext_hi;
   logic [DATA_W-1:0]   w_ext_lo;
   logic [DATA_W-1:0]   w_ext_data;

   // A request crosses into the next word when its last byte lies past the
   // end of the addressed word.
   always_comb begin
      w_req_split = (int'(req_offset) + nbytes(req_size, NB)) > NB;
   end

   // Feed the extractor the response being captured this cycle so the
   // result can be registered on the same edge that enters RESP; a
   // non-split load sees an all-zero hi word.
   always_comb begin
      w_ext_lo = (state_q == ST_FETCH_LO) ? mem_rsp_data : lo_q;
      w_ext_hi = (state_q == ST_FETCH_HI) ? mem_rsp_data : '0;
   end

   lane_extract_extend #(
      .DATA_W (DATA_W)
   ) u_extract (
      .i_hi     (w_ext_hi),
      .i_lo     (w_ext_lo),
      .i_offset (offset_q),
      .i_size   (size_q),
      .i_sign   (sign_q),
      .o_data   (w_ext_data)
   );

   // Next-state, capture and handshake logic.
   always_comb begin
      state_d       = state_q;
      offset_d      = offset_q;
      size_d        = size_q;
      sign_d        = sign_q;
      split_d       = split_q;
      tag_d         = tag_q;
      lo_d          = lo_q;
      resp_data_d   = resp_data_q;
      resp_tag_d    = resp_tag_q;
      resp_err_d    = resp_err_q;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_hi    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               offset_d = req_offset;
               size_d   = req_size;
               sign_d   = req_sign;
               tag_d    = req_tag;
               split_d  = w_req_split;
               if (w_req_split && (ALLOW_MISALIGN == 0)) begin
                  state_d     = ST_RESP;
                  resp_err_d  = 1'b1;
                  resp_data_d = '0;
                  resp_tag_d  = req_tag;
               end else begin
                  state_d = ST_FETCH_LO;
               end
            end
         end
         ST_FETCH_LO: begin
            mem_req_valid = 1'b1;
            if (mem_rsp_valid) begin
               lo_d = mem_rsp_data;
               if (split_q) begin
                  state_d = ST_FETCH_HI;
               end else begin
                  state_d     = ST_RESP;
                  resp_data_d = w_ext_data;
                  resp_err_d  = 1'b0;
                  resp_tag_d  = tag_q;
               end
            end
         end
         ST_FETCH_HI: begin
            mem_req_valid = 1'b1;
            mem_req_hi    = 1'b1;
            if (mem_rsp_valid) begin
               state_d     = ST_RESP;
               resp_data_d = w_ext_data;
               resp_err_d  = 1'b0;
               resp_tag_d  = tag_q;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and capture registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         offset_q    <= '0;
         size_q      <= SZ_BYTE;
         sign_q      <= 1'b0;
         split_q     <= 1'b0;
         tag_q       <= '0;
         lo_q        <= '0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         split_q     <= split_d;
         tag_q       <= tag_d;
         lo_q        <= lo_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign resp_valid = (state_q == ST_RESP);
   assign resp_data  = resp_data_q;
   assign resp_tag   = resp_tag_q;
   assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_align_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_load_align_extend                                   |
// | Description : Self-checking bench for load_align_extend: directed    |
// |               vector table, random loads against a reference model,  |
// |               backpressure, misalign reject and mid-fetch reset.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_load_align_extend;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_valid2 = 1'b0;
   logic [1:0]  req_offset = '0;
   logic [1:0]  req_size = '0;
   logic        req_sign = 1'b0;
   logic [4:0]  req_tag = '0;
   logic        resp_ready = 1'b1;
   logic        resp_ready2 = 1'b1;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        mem_rsp_valid2 = 1'b0;
   logic [31:0] mem_rsp_data2 = '0;

   logic        req_ready, mem_req_valid, mem_req_hi, resp_valid, resp_err;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;
   logic        req_ready2, mem_req_valid2, mem_req_hi2, resp_valid2, resp_err2;
   logic [31:0] resp_data2;
   logic [4:0]  resp_tag2;

   // memory model controls and counters
   logic [31:0] word_lo = '0;
   logic [31:0] word_hi = '0;
   logic        block_hi = 1'b0;
   logic        force_pulse = 1'b0;
   int          n_req = 0;
   int          hi_cnt = 0;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   load_align_extend #(.DATA_W(32), .TAG_W(5), .ALLOW_MISALIGN(1)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_offset(req_offset), .req_size(req_size), .req_sign(req_sign), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid), .mem_req_hi(mem_req_hi),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_err(resp_err));

   load_align_extend #(.DATA_W(32), .TAG_W(5), .ALLOW_MISALIGN(0)) dut_strict (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_offset(req_offset), .req_size(req_size), .req_sign(req_sign), .req_tag(req_tag),
      .mem_req_valid(mem_req_valid2), .mem_req_hi(mem_req_hi2),
      .mem_rsp_valid(mem_rsp_valid2), .mem_rsp_data(mem_rsp_data2),
      .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_data(resp_data2),
      .resp_tag(resp_tag2), .resp_err(resp_err2));

   // One-cycle-latency memory: answers each outstanding request with a single pulse.
   always @(posedge clock) begin
      mem_rsp_valid <= 1'b0;
      if (force_pulse) begin
         mem_rsp_valid <= 1'b1;
         mem_rsp_data  <= 32'hCAFEF00D;
      end else if (mem_req_valid && !mem_rsp_valid && !(block_hi && mem_req_hi)) begin
         mem_rsp_valid <= 1'b1;
         mem_rsp_data  <= mem_req_hi ? word_hi : word_lo;
         n_req         <= n_req + 1;
         if (mem_req_hi) hi_cnt <= hi_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: pick the addressed bytes out of the little-endian word pair.
   function automatic logic [31:0] ref_load(input logic [1:0] off, input logic [1:0] size,
                                            input logic sign, input logic [31:0] lo,
                                            input logic [31:0] hi, output bit split);
      int nb;
      longint unsigned pair, mask, val;
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      split = (int'(off) + nb) > 4;
      pair  = split ? {hi, lo} : {32'h0, lo};
      pair  = pair >> (8 * int'(off));
      mask  = (64'd1 << (8 * nb)) - 64'd1;
      val   = pair & mask;
      if (sign && (((val >> (8 * nb - 1)) & 64'd1) != 0)) val = val | ~mask;
      return val[31:0];
   endfunction

   // Issue one load on the main instance and wait (bounded) for its response.
   task automatic do_load(input logic [1:0] off, input logic [1:0] size, input logic sign,
                          input logic [4:0] tag, input logic [31:0] lo, input logic [31:0] hi,
                          output logic [31:0] d, output logic err, output logic [4:0] t,
                          output int nreq, output int nhi);
      int n0, h0, k;
      word_lo = lo;
      word_hi = hi;
      n0 = n_req;
      h0 = hi_cnt;
      @(negedge clock);
      req_offset = off; req_size = size; req_sign = sign; req_tag = tag; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      k = 0;
      while (!resp_valid && k < 40) begin
         @(negedge clock);
         k++;
      end
      if (!resp_valid) chk("resp_timeout", 64'd0, 64'd1);
      d = resp_data; err = resp_err; t = resp_tag;
      @(negedge clock);
      nreq = n_req - n0;
      nhi  = hi_cnt - h0;
   endtask

   typedef struct {
      logic [1:0]  off;
      logic [1:0]  size;
      logic        sign;
      logic [4:0]  tag;
      logic [31:0] lo;
      logic [31:0] hi;
      logic [31:0] exp;
      int          nreq;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] d, ed;
      logic        err;
      logic [4:0]  t;
      int          nreq, nhi, k;
      bit          sp;

      vecs[0] = '{2'd3, 2'd0, 1'b1, 5'd1, 32'h80112233, 32'hFFFFFFFF, 32'hFFFFFF80, 1};
      vecs[1] = '{2'd2, 2'd1, 1'b0, 5'd2, 32'hBEEF1234, 32'hFFFFFFFF, 32'h0000BEEF, 1};
      vecs[2] = '{2'd3, 2'd2, 1'b1, 5'd3, 32'hAA000000, 32'h00332211, 32'h332211AA, 2};
      vecs[3] = '{2'd1, 2'd1, 1'b1, 5'd4, 32'h00ABCD00, 32'h12345678, 32'hFFFFABCD, 1};
      vecs[4] = '{2'd3, 2'd1, 1'b0, 5'd5, 32'h12000000, 32'h00000034, 32'h00003412, 2};
      vecs[5] = '{2'd0, 2'd3, 1'b0, 5'd6, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 1};
      vecs[6] = '{2'd2, 2'd0, 1'b0, 5'd7, 32'h00800000, 32'hFFFFFFFF, 32'h00000080, 1};
      vecs[7] = '{2'd1, 2'd3, 1'b1, 5'd8, 32'h44332211, 32'h88776655, 32'h55443322, 2};

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rst_mem_req_hi", {63'd0, mem_req_hi}, 64'd0);
      chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
      chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
      chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

      // directed vectors
      foreach (vecs[i]) begin
         do_load(vecs[i].off, vecs[i].size, vecs[i].sign, vecs[i].tag, vecs[i].lo, vecs[i].hi,
                 d, err, t, nreq, nhi);
         chk($sformatf("vec%0d_data", i), {32'd0, d}, {32'd0, vecs[i].exp});
         chk($sformatf("vec%0d_err", i), {63'd0, err}, 64'd0);
         chk($sformatf("vec%0d_tag", i), {59'd0, t}, {59'd0, vecs[i].tag});
         chk($sformatf("vec%0d_nreq", i), 64'(nreq), 64'(vecs[i].nreq));
         chk($sformatf("vec%0d_nhi", i), 64'(nhi), 64'(vecs[i].nreq - 1));
      end

      // random loads against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [1:0]  o, s;
         logic        sg;
         logic [4:0]  tg;
         logic [31:0] lo, hi;
         o  = 2'($urandom_range(0, 3));
         s  = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         tg = 5'($urandom_range(0, 31));
         lo = $urandom;
         hi = $urandom;
         ed = ref_load(o, s, sg, lo, hi, sp);
         do_load(o, s, sg, tg, lo, hi, d, err, t, nreq, nhi);
         chk($sformatf("rnd%0d_data", i), {32'd0, d}, {32'd0, ed});
         chk($sformatf("rnd%0d_tag", i), {59'd0, t}, {59'd0, tg});
         chk($sformatf("rnd%0d_nreq", i), 64'(nreq), sp ? 64'd2 : 64'd1);
      end

      // backpressure: result held while write-back stalls
      resp_ready = 1'b0;
      do_load(2'd0, 2'd1, 1'b1, 5'd10, 32'h55558001, 32'h0, d, err, t, nreq, nhi);
      chk("bp_data", {32'd0, d}, 64'hFFFF8001);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_tag   = 5'd11;
         @(negedge clock);
         chk($sformatf("bp%0d_valid", i), {63'd0, resp_valid}, 64'd1);
         chk($sformatf("bp%0d_data", i), {32'd0, resp_data}, 64'hFFFF8001);
         chk($sformatf("bp%0d_tag", i), {59'd0, resp_tag}, 64'd10);
         chk($sformatf("bp%0d_req_ready", i), {63'd0, req_ready}, 64'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_valid", {63'd0, resp_valid}, 64'd0);
      chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
      do_load(2'd1, 2'd0, 1'b0, 5'd12, 32'h0000F700, 32'h0, d, err, t, nreq, nhi);
      chk("bp_next_data", {32'd0, d}, 64'h000000F7);
      chk("bp_next_tag", {59'd0, t}, 64'd12);

      // misaligned access rejected on the strict instance
      @(negedge clock);
      req_offset = 2'd1; req_size = 2'd2; req_sign = 1'b1; req_tag = 5'd9; req_valid2 = 1'b1;
      @(negedge clock);
      req_valid2 = 1'b0;
      chk("mis_valid", {63'd0, resp_valid2}, 64'd1);
      chk("mis_err", {63'd0, resp_err2}, 64'd1);
      chk("mis_data", {32'd0, resp_data2}, 64'd0);
      chk("mis_tag", {59'd0, resp_tag2}, 64'd9);
      chk("mis_mem_req", {63'd0, mem_req_valid2}, 64'd0);
      @(negedge clock);
      chk("mis_back_idle", {63'd0, req_ready2}, 64'd1);

      // reset while waiting for the hi word, then a stray memory pulse
      block_hi = 1'b1;
      word_lo  = 32'hAA000000;
      @(negedge clock);
      req_offset = 2'd3; req_size = 2'd2; req_sign = 1'b0; req_tag = 5'd13; req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      k = 0;
      while (!mem_req_hi && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk("rh_reached_fetch_hi", {63'd0, mem_req_hi}, 64'd1);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n     = 1'b1;
      force_pulse = 1'b1;
      @(negedge clock);
      force_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("rh%0d_resp_valid", i), {63'd0, resp_valid}, 64'd0);
         chk($sformatf("rh%0d_req_ready", i), {63'd0, req_ready}, 64'd1);
         chk($sformatf("rh%0d_mem_req", i), {63'd0, mem_req_valid}, 64'd0);
      end
      block_hi = 1'b0;
      do_load(2'd0, 2'd2, 1'b0, 5'd14, 32'h01020304, 32'h0, d, err, t, nreq, nhi);
      chk("rh_after_data", {32'd0, d}, 64'h01020304);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
